// File: rtl/aesl_deadlock_watchdog_ctrl_if.sv
// Bundle of control, blocking-tap and status signals for the deadlock watchdog.
// The master side drives enable/clear and the raw taps; the slave side is the
// watchdog, which returns the registered status.
interface aesl_deadlock_watchdog_ctrl_if #(
  parameter int N_AXIS = 2,
  parameter int N_INST = 1,
  parameter int CNT_W  = 16
);
  logic                       enable;
  logic                       clear;
  logic [N_AXIS-1:0]          axis_block_sigs;
  logic [N_INST-1:0]          inst_idle_sigs;
  logic [N_INST-1:0]          inst_block_sigs;
  logic                       block;
  logic                       block_pulse;
  logic                       suspect;
  logic [N_AXIS+N_INST-1:0]   block_mask;
  logic [CNT_W-1:0]           stall_cycles;
  logic [CNT_W-1:0]           block_count;

  modport master (
    output enable, clear, axis_block_sigs, inst_idle_sigs, inst_block_sigs,
    input  block, block_pulse, suspect, block_mask, stall_cycles, block_count
  );

  modport slave (
    input  enable, clear, axis_block_sigs, inst_idle_sigs, inst_block_sigs,
    output block, block_pulse, suspect, block_mask, stall_cycles, block_count
  );
endinterface

// File: rtl/aesl_deadlock_watchdog_ctrl.sv
// Debounced kernel-deadlock detector. A stall pattern must persist unchanged
// for THRESH consecutive samples before the kernel is declared blocked; the
// block is latched until the stall clears, software clears it, or monitoring
// is disabled. All status outputs come straight from flops.
module aesl_deadlock_watchdog_ctrl #(
  parameter int N_AXIS = 2,
  parameter int N_INST = 1,
  parameter int THRESH = 16,
  parameter int CNT_W  = 16
) (
  input  logic                          clock,
  input  logic                          reset,
  aesl_deadlock_watchdog_ctrl_if.slave  bus
);

  localparam int PAT_W = N_AXIS + N_INST;

  localparam logic [1:0] S_IDLE    = 2'd0;
  localparam logic [1:0] S_WATCH   = 2'd1;
  localparam logic [1:0] S_SUSPECT = 2'd2;
  localparam logic [1:0] S_BLOCKED = 2'd3;

  localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0] THRESH_C = CNT_W'(THRESH);
  localparam bit               THRESH_ONE = (THRESH == 1);

  // Counter increment that sticks at all-ones instead of wrapping.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : (v + CNT_ONE);
  endfunction

  logic [1:0]       state_q, state_d;
  logic [PAT_W-1:0] pat_q, pat_d;
  logic [CNT_W-1:0] stall_cycles_q, stall_cycles_d;
  logic [CNT_W-1:0] block_count_q, block_count_d;
  logic [PAT_W-1:0] block_mask_q, block_mask_d;
  logic             block_q, block_d;
  logic             block_pulse_q, block_pulse_d;
  logic             suspect_q, suspect_d;

  logic [PAT_W-1:0] pat_s;
  logic             stall_s;
  logic             enter_s;
  logic [CNT_W-1:0] stall_inc_s;
  logic [CNT_W-1:0] count_base_s;

  // Current blocking pattern and whether it counts as a genuine stall
  // (an all-idle kernel is never considered stuck).
  always_comb begin
    pat_s   = {bus.inst_block_sigs, bus.axis_block_sigs};
    stall_s = (|pat_s) & ~(&bus.inst_idle_sigs);
  end

  // Next-state, stall counter, pattern register and event bookkeeping.
  always_comb begin
    state_d        = state_q;
    pat_d          = pat_q;
    stall_cycles_d = stall_cycles_q;
    enter_s        = 1'b0;
    stall_inc_s    = stall_cycles_q + CNT_ONE;
    count_base_s   = bus.clear ? CNT_ZERO : block_count_q;

    if (!bus.enable) begin
      state_d        = S_IDLE;
      stall_cycles_d = CNT_ZERO;
    end else begin
      case (state_q)
        S_IDLE: begin
          state_d        = S_WATCH;
          stall_cycles_d = CNT_ZERO;
        end
        S_WATCH: begin
          if (stall_s) begin
            pat_d = pat_s;
            if (THRESH_ONE) begin
              state_d        = S_BLOCKED;
              stall_cycles_d = THRESH_C;
              enter_s        = 1'b1;
            end else begin
              state_d        = S_SUSPECT;
              stall_cycles_d = CNT_ONE;
            end
          end else begin
            stall_cycles_d = CNT_ZERO;
          end
        end
        S_SUSPECT: begin
          if (!stall_s) begin
            state_d        = S_WATCH;
            stall_cycles_d = CNT_ZERO;
          end else if (pat_s != pat_q) begin
            // A different stall pattern means different stuck channels: restart.
            pat_d          = pat_s;
            stall_cycles_d = CNT_ONE;
          end else begin
            stall_cycles_d = stall_inc_s;
            if (stall_inc_s == THRESH_C) begin
              state_d = S_BLOCKED;
              enter_s = 1'b1;
            end else begin
              state_d = S_SUSPECT;
            end
          end
        end
        S_BLOCKED: begin
          if (!stall_s || bus.clear) begin
            state_d        = S_WATCH;
            stall_cycles_d = CNT_ZERO;
          end else begin
            stall_cycles_d = THRESH_C;
          end
        end
        default: begin
          state_d        = S_IDLE;
          stall_cycles_d = CNT_ZERO;
        end
      endcase
    end

    // Clear zeroes the count first so a coincident entry still registers as 1.
    block_count_d = enter_s ? sat_inc(count_base_s) : count_base_s;
    block_mask_d  = enter_s ? pat_s : block_mask_q;
    block_pulse_d = enter_s;
    block_d       = (state_d == S_BLOCKED);
    suspect_d     = (state_d == S_SUSPECT);
  end

  // State and status registers with synchronous reset.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q        <= S_IDLE;
      pat_q          <= {PAT_W{1'b0}};
      stall_cycles_q <= CNT_ZERO;
      block_count_q  <= CNT_ZERO;
      block_mask_q   <= {PAT_W{1'b0}};
      block_q        <= 1'b0;
      block_pulse_q  <= 1'b0;
      suspect_q      <= 1'b0;
    end else begin
      state_q        <= state_d;
      pat_q          <= pat_d;
      stall_cycles_q <= stall_cycles_d;
      block_count_q  <= block_count_d;
      block_mask_q   <= block_mask_d;
      block_q        <= block_d;
      block_pulse_q  <= block_pulse_d;
      suspect_q      <= suspect_d;
    end
  end

  assign bus.block        = block_q;
  assign bus.block_pulse  = block_pulse_q;
  assign bus.suspect      = suspect_q;
  assign bus.block_mask   = block_mask_q;
  assign bus.stall_cycles = stall_cycles_q;
  assign bus.block_count  = block_count_q;

endmodule

// File: tb/tb_aesl_deadlock_watchdog_ctrl.sv
// Bench for the deadlock watchdog: one instance with THRESH=16/CNT_W=16 and
// one with THRESH=1/CNT_W=4, both compared against a run-length model.
module tb_aesl_deadlock_watchdog_ctrl;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  aesl_deadlock_watchdog_ctrl_if #(.N_AXIS(2), .N_INST(1), .CNT_W(16)) if_a ();
  aesl_deadlock_watchdog_ctrl_if #(.N_AXIS(2), .N_INST(1), .CNT_W(4))  if_b ();

  aesl_deadlock_watchdog_ctrl #(.N_AXIS(2), .N_INST(1), .THRESH(16), .CNT_W(16)) dut_a (
    .clock(clk), .reset(rst), .bus(if_a.slave));
  aesl_deadlock_watchdog_ctrl #(.N_AXIS(2), .N_INST(1), .THRESH(1), .CNT_W(4)) dut_b (
    .clock(clk), .reset(rst), .bus(if_b.slave));

  int checks = 0;
  int errors = 0;

  // Reference model: run length of an identical stall pattern.
  int         thresh [2] = '{16, 1};
  int         cmax   [2] = '{65535, 15};
  bit         m_active  [2];
  bit         m_blocked [2];
  bit         m_pulse   [2];
  int         m_run     [2];
  logic [2:0] m_last    [2];
  logic [2:0] m_mask    [2];
  int         m_count   [2];

  task automatic model_step(input int i, input bit r, input bit en, input bit clr,
                            input logic [1:0] axis, input logic idle, input logic blk);
    logic [2:0] pat;
    bit stall;
    pat = {blk, axis};
    stall = (pat != 3'b000) && !idle;
    m_pulse[i] = 1'b0;
    if (r) begin
      m_active[i] = 1'b0; m_blocked[i] = 1'b0; m_run[i] = 0;
      m_last[i] = 3'b000; m_mask[i] = 3'b000; m_count[i] = 0;
      return;
    end
    if (clr) m_count[i] = 0;
    if (!en) begin
      m_active[i] = 1'b0; m_blocked[i] = 1'b0; m_run[i] = 0;
    end else if (!m_active[i]) begin
      m_active[i] = 1'b1;
    end else if (m_blocked[i]) begin
      if (!stall || clr) begin
        m_blocked[i] = 1'b0; m_run[i] = 0;
      end
    end else if (stall) begin
      if (m_run[i] > 0 && pat == m_last[i]) m_run[i] = m_run[i] + 1;
      else m_run[i] = 1;
      m_last[i] = pat;
      if (m_run[i] == thresh[i]) begin
        m_blocked[i] = 1'b1;
        m_pulse[i]   = 1'b1;
        m_mask[i]    = pat;
        if (m_count[i] < cmax[i]) m_count[i] = m_count[i] + 1;
      end
    end else begin
      m_run[i] = 0;
    end
  endtask

  function automatic logic [37:0] exp_v(input int i);
    bit sus;
    sus = m_active[i] && !m_blocked[i] && (m_run[i] > 0);
    return {m_blocked[i], m_pulse[i], sus, m_mask[i], 16'(m_run[i]), 16'(m_count[i])};
  endfunction

  function automatic logic [37:0] got_a();
    return {if_a.block, if_a.block_pulse, if_a.suspect, if_a.block_mask,
            if_a.stall_cycles, if_a.block_count};
  endfunction

  function automatic logic [37:0] got_b();
    return {if_b.block, if_b.block_pulse, if_b.suspect, if_b.block_mask,
            12'h000, if_b.stall_cycles, 12'h000, if_b.block_count};
  endfunction

  // Advance one clock: update the model from the driven inputs, then sample after the edge.
  task automatic tick();
    model_step(0, rst, if_a.enable, if_a.clear, if_a.axis_block_sigs,
               if_a.inst_idle_sigs[0], if_a.inst_block_sigs[0]);
    model_step(1, rst, if_b.enable, if_b.clear, if_b.axis_block_sigs,
               if_b.inst_idle_sigs[0], if_b.inst_block_sigs[0]);
    @(posedge clk);
    #1;
  endtask

  task automatic drive_a(input bit en, input bit clr, input logic [1:0] axis,
                         input logic idle, input logic blk);
    if_a.enable = en; if_a.clear = clr; if_a.axis_block_sigs = axis;
    if_a.inst_idle_sigs = idle; if_a.inst_block_sigs = blk;
  endtask

  task automatic drive_b(input bit en, input bit clr, input logic [1:0] axis,
                         input logic idle, input logic blk);
    if_b.enable = en; if_b.clear = clr; if_b.axis_block_sigs = axis;
    if_b.inst_idle_sigs = idle; if_b.inst_block_sigs = blk;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    drive_a(1'b0, 1'b0, 2'b00, 1'b0, 1'b0);
    drive_b(1'b0, 1'b0, 2'b00, 1'b0, 1'b0);
    repeat (3) tick();
    checks++;
    if (got_a() !== 38'd0) begin
      errors++; $display("FAIL reset_a got %h expected 0", got_a());
    end
    checks++;
    if (got_b() !== 38'd0) begin
      errors++; $display("FAIL reset_b got %h expected 0", got_b());
    end
    rst = 1'b0;
  endtask

  task automatic test_basic_block();
    drive_a(1'b1, 1'b0, 2'b00, 1'b0, 1'b0);
    tick();
    drive_a(1'b1, 1'b0, 2'b01, 1'b0, 1'b0);
    for (int s = 1; s <= 17; s++) begin
      tick();
      checks++;
      if (got_a() !== exp_v(0)) begin
        errors++; $display("FAIL basic sample %0d got %h expected %h", s, got_a(), exp_v(0));
      end
      checks++;
      if (if_a.suspect !== (s <= 15)) begin
        errors++; $display("FAIL basic_suspect sample %0d got %b", s, if_a.suspect);
      end
      checks++;
      if (if_a.block_pulse !== (s == 16)) begin
        errors++; $display("FAIL basic_pulse sample %0d got %b", s, if_a.block_pulse);
      end
    end
    checks++;
    if (if_a.block_mask !== 3'b001 || if_a.block_count !== 16'd1) begin
      errors++; $display("FAIL basic_mask_count got %b/%0d expected 001/1",
                         if_a.block_mask, if_a.block_count);
    end
    drive_a(1'b1, 1'b0, 2'b00, 1'b0, 1'b0);
    tick();
    checks++;
    if (if_a.block !== 1'b0 || got_a() !== exp_v(0)) begin
      errors++; $display("FAIL basic_release got %h expected %h", got_a(), exp_v(0));
    end
  endtask

  task automatic test_pattern_change();
    drive_a(1'b1, 1'b0, 2'b01, 1'b0, 1'b0);
    repeat (10) tick();
    drive_a(1'b1, 1'b0, 2'b10, 1'b0, 1'b0);
    for (int s = 1; s <= 16; s++) begin
      tick();
      checks++;
      if (got_a() !== exp_v(0) || if_a.stall_cycles !== 16'(s)) begin
        errors++; $display("FAIL pattern sample %0d got %h expected %h", s, got_a(), exp_v(0));
      end
      checks++;
      if (if_a.block !== (s == 16)) begin
        errors++; $display("FAIL pattern_block sample %0d got %b", s, if_a.block);
      end
    end
    checks++;
    if (if_a.block_mask !== 3'b010) begin
      errors++; $display("FAIL pattern_mask got %b expected 010", if_a.block_mask);
    end
    drive_a(1'b1, 1'b0, 2'b00, 1'b0, 1'b0);
    tick();
  endtask

  task automatic test_idle_masks_stall();
    drive_a(1'b1, 1'b0, 2'b11, 1'b1, 1'b1);
    for (int s = 0; s < 100; s++) begin
      tick();
      checks++;
      if (got_a() !== exp_v(0) || if_a.block !== 1'b0 || if_a.stall_cycles !== 16'd0) begin
        errors++; $display("FAIL idle cycle %0d got %h expected %h", s, got_a(), exp_v(0));
      end
    end
    drive_a(1'b1, 1'b0, 2'b00, 1'b0, 1'b0);
    tick();
  endtask

  task automatic test_clear();
    drive_a(1'b1, 1'b0, 2'b01, 1'b0, 1'b0);
    repeat (16) tick();
    checks++;
    if (if_a.block !== 1'b1 || got_a() !== exp_v(0)) begin
      errors++; $display("FAIL clear_setup got %h expected %h", got_a(), exp_v(0));
    end
    drive_a(1'b1, 1'b1, 2'b01, 1'b0, 1'b0);
    tick();
    checks++;
    if (if_a.block !== 1'b0 || if_a.block_count !== 16'd0) begin
      errors++; $display("FAIL clear_release got block=%b count=%0d expected 0/0",
                         if_a.block, if_a.block_count);
    end
    drive_a(1'b1, 1'b0, 2'b01, 1'b0, 1'b0);
    for (int s = 1; s <= 16; s++) begin
      tick();
      checks++;
      if (got_a() !== exp_v(0)) begin
        errors++; $display("FAIL clear_rerun sample %0d got %h expected %h", s, got_a(), exp_v(0));
      end
    end
    checks++;
    if (if_a.block !== 1'b1 || if_a.block_count !== 16'd1) begin
      errors++; $display("FAIL clear_reblock got block=%b count=%0d expected 1/1",
                         if_a.block, if_a.block_count);
    end
    drive_a(1'b1, 1'b0, 2'b00, 1'b0, 1'b0);
    tick();
  endtask

  task automatic test_thresh_one_saturation();
    drive_b(1'b0, 1'b1, 2'b00, 1'b0, 1'b0);
    tick();
    drive_b(1'b1, 1'b0, 2'b00, 1'b0, 1'b0);
    tick();
    for (int r = 0; r < 19; r++) begin
      drive_b(1'b1, 1'b0, 2'(r % 3 + 1), 1'b0, 1'b0);
      tick();
      checks++;
      if (if_b.block_pulse !== 1'b1 || if_b.block !== 1'b1 || got_b() !== exp_v(1)) begin
        errors++; $display("FAIL t1_pulse rep %0d got %h expected %h", r, got_b(), exp_v(1));
      end
      drive_b(1'b1, 1'b0, 2'b00, 1'b0, 1'b0);
      tick();
      checks++;
      if (if_b.block !== 1'b0 || if_b.block_pulse !== 1'b0 || got_b() !== exp_v(1)) begin
        errors++; $display("FAIL t1_drop rep %0d got %h expected %h", r, got_b(), exp_v(1));
      end
    end
    checks++;
    if (if_b.block_count !== 4'd15) begin
      errors++; $display("FAIL t1_saturate got %0d expected 15", if_b.block_count);
    end
    drive_b(1'b0, 1'b0, 2'b00, 1'b0, 1'b0);
    tick();
  endtask

  task automatic test_reset_mid_suspect();
    drive_a(1'b1, 1'b0, 2'b11, 1'b0, 1'b0);
    repeat (7) tick();
    checks++;
    if (if_a.stall_cycles !== 16'd7 || if_a.suspect !== 1'b1) begin
      errors++; $display("FAIL midrst_setup got stall=%0d suspect=%b expected 7/1",
                         if_a.stall_cycles, if_a.suspect);
    end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    checks++;
    if (got_a() !== 38'd0 || got_a() !== exp_v(0)) begin
      errors++; $display("FAIL midrst got %h expected 0", got_a());
    end
    drive_a(1'b1, 1'b0, 2'b00, 1'b0, 1'b0);
    tick();
  endtask

  task automatic test_disable_mid_suspect();
    drive_a(1'b1, 1'b0, 2'b10, 1'b0, 1'b1);
    repeat (16) tick();
    drive_a(1'b1, 1'b0, 2'b00, 1'b0, 1'b0);
    tick();
    drive_a(1'b1, 1'b0, 2'b01, 1'b0, 1'b0);
    repeat (7) tick();
    drive_a(1'b0, 1'b0, 2'b01, 1'b0, 1'b0);
    tick();
    checks++;
    if (if_a.suspect !== 1'b0 || if_a.stall_cycles !== 16'd0 || if_a.block !== 1'b0 ||
        if_a.block_count !== 16'd1 || if_a.block_mask !== 3'b110) begin
      errors++; $display("FAIL disable got %h expected %h", got_a(), exp_v(0));
    end
    checks++;
    if (got_a() !== exp_v(0)) begin
      errors++; $display("FAIL disable_model got %h expected %h", got_a(), exp_v(0));
    end
  endtask

  task automatic test_random();
    logic [2:0] pa, pb;
    bit ea, eb;
    pa = 3'b001; pb = 3'b001; ea = 1'b1; eb = 1'b1;
    for (int c = 0; c < 4000; c++) begin
      if ($urandom_range(39, 0) == 0) pa = 3'($urandom_range(7, 0));
      if ($urandom_range(3, 0) == 0)  pb = 3'($urandom_range(7, 0));
      if ($urandom_range(199, 0) == 0) ea = ~ea;
      if ($urandom_range(99, 0) == 0)  eb = ~eb;
      rst = ($urandom_range(999, 0) == 0);
      drive_a(ea, ($urandom_range(99, 0) < 2), pa[1:0], ($urandom_range(49, 0) == 0), pa[2]);
      drive_b(eb, ($urandom_range(49, 0) == 0), pb[1:0], ($urandom_range(9, 0) == 0), pb[2]);
      tick();
      checks++;
      if (got_a() !== exp_v(0)) begin
        errors++; $display("FAIL random_a cycle %0d got %h expected %h", c, got_a(), exp_v(0));
      end
      checks++;
      if (got_b() !== exp_v(1)) begin
        errors++; $display("FAIL random_b cycle %0d got %h expected %h", c, got_b(), exp_v(1));
      end
    end
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    drive_a(1'b0, 1'b0, 2'b00, 1'b0, 1'b0);
    drive_b(1'b0, 1'b0, 2'b00, 1'b0, 1'b0);
    test_reset();
    test_basic_block();
    test_pattern_change();
    test_idle_masks_stall();
    test_clear();
    test_thresh_one_saturation();
    test_reset_mid_suspect();
    test_disable_mid_suspect();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/aesl_deadlock_watchdog_ctrl.md
# aesl_deadlock_watchdog_ctrl

Sequencing controller for the simulation deadlock-monitor path of the `myproject_axi` kernel. It samples the per-channel AXI-stream blocking flags (`in_r`, `out_r`) and the per-instance idle/block flags every cycle. It runs a watch/suspect/blocked state machine with a programmable persistence threshold and emits a latched kernel-block flag, a one-cycle detection pulse and a snapshot of the blocking channels. It sits between the raw blocking-signal taps and the top-level kernel monitor, replacing the unfiltered combinational block decision with a debounced, counted one.

## Interface
Parameters:
- `N_AXIS`, 2: number of AXI-stream blocking inputs (bit 0 = `in_r`, bit 1 = `out_r`).
- `N_INST`, 1: number of sub-instance idle/block inputs.
- `THRESH`, 16: consecutive stall samples with an unchanged pattern required to declare a block. Legal range is 1 ≤ THRESH ≤ 2^CNT_W − 1.
- `CNT_W`, 16: width of the stall and event counters.

Ports:
- `clock` in 1: single clock; all state updates on rising edge.
- `reset` in 1: synchronous, active-high.
- `enable` in 1: monitoring enabled.
- `clear` in 1: one-cycle request to clear the event counter and release a latched block.
- `axis_block_sigs` in N_AXIS: 1 = that stream is stalled.
- `inst_idle_sigs` in N_INST: 1 = instance idle.
- `inst_block_sigs` in N_INST: 1 = instance blocked.
- `block` out 1: latched kernel-block flag.
- `block_pulse` out 1: one-cycle pulse on entry to BLOCKED.
- `suspect` out 1: high while in SUSPECT.
- `block_mask` out N_AXIS+N_INST: pattern captured on entry to BLOCKED, ordered as {inst_block_sigs, axis_block_sigs}.
- `stall_cycles` out CNT_W: current consecutive-stall count.
- `block_count` out CNT_W: number of BLOCKED entries, saturating at all-ones.

## Operation
- Combinational terms per cycle:
  - `pat` = {inst_block_sigs, axis_block_sigs}.
  - `stall` = (|pat) & ~(&inst_idle_sigs).
- All outputs are registered.
- States: IDLE, WATCH, SUSPECT, BLOCKED.
- IDLE:
  - `enable`=1 goes to WATCH.
  - `stall_cycles`=0, `block`=0, `suspect`=0.
- WATCH:
  - `stall`=1 goes to SUSPECT, with `stall_cycles`=1 and the pattern register set to `pat`.
  - If THRESH=1, it goes directly to BLOCKED instead.
- SUSPECT:
  - `stall`=0 goes to WATCH and sets `stall_cycles`=0.
  - `stall`=1 with `pat` ≠ the pattern register restarts: `stall_cycles`=1, pattern register = `pat`.
  - Otherwise `stall_cycles`+1. When the incremented value equals THRESH, go to BLOCKED.
- Entry to BLOCKED:
  - `block`←1, `block_pulse`←1 for that cycle only.
  - `block_mask`←`pat`.
  - `block_count`+1, saturating.
- BLOCKED:
  - `stall_cycles` holds at THRESH.
  - `stall`=0 goes to WATCH, with `block`←0 and `stall_cycles`=0. `block_mask` holds its last value.
  - A pattern change while still stalled stays in BLOCKED and does not produce a new pulse.
- `clear`:
  - `block_count`←0.
  - In BLOCKED: go to WATCH and set `block`←0.
  - If `clear` coincides with an entry to BLOCKED, entry wins for the state. `block_count` ends at 1, `block_pulse`=1.
- `enable`=0 from any state: go to IDLE next cycle and clear `block`, `suspect`, `stall_cycles`. `block_count` and `block_mask` are retained.
- `reset` takes priority over everything. On reset: state=IDLE; every output, the pattern register and `block_count` = 0.

## Timing
- Latency: with a constant stalled `pat` first sampled at edge k, `block`/`block_pulse` are visible after edge k+THRESH−1. For THRESH=1 they are visible after edge k.
- Release: `block` falls one edge after the first non-stall sample.
- `block_pulse` lasts exactly one cycle per BLOCKED entry.
- `suspect` is high exactly while the state is SUSPECT.
- No combinational paths from inputs to outputs.
- `stall_cycles` never exceeds THRESH, so it cannot wrap.
- `block_count` saturates at 2^CNT_W−1 and does not wrap.
- Reset asserted mid-SUSPECT or mid-BLOCKED: all outputs 0 after that edge.

## Test plan
- Reset then `enable`=1, hold `axis_block_sigs`=2'b01, `inst_idle_sigs`=0 for 16 cycles (THRESH=16):
  - `suspect` high for samples 1–15.
  - `block_pulse` once after the 16th sample.
  - `block_mask`=3'b001, `block_count`=1.
- Stall for 10 cycles, change the pattern to 2'b10, stall 16 more cycles:
  - `stall_cycles` restarts at 1.
  - `block` asserts after the 16th sample of the new pattern.
  - `block_mask`=3'b010.
- Stall with `inst_idle_sigs`=1 for 100 cycles: state stays WATCH, `block`=0, `stall_cycles`=0.
- In BLOCKED, assert `clear`:
  - `block`=0 and `block_count`=0 next cycle.
  - A still-present stall restarts SUSPECT on the following sample, and `block` re-asserts after 16 samples with `block_count`=1.
- THRESH=1 with a single-cycle stall:
  - `block_pulse` after that edge, `block` drops one edge later.
  - Repeating 2^CNT_W+3 times (CNT_W=4) leaves `block_count`=15.
- Mid-SUSPECT (`stall_cycles`=7):
  - Assert `reset`: all outputs 0.
  - Alternatively drop `enable`: IDLE with `block_count` retained.
